// File: rtl/mem_read_addr_gen.sv
// rtl/mem_read_addr_gen.sv - 2-D read-address sequencer feeding the skewed BRAM read fan-out.
// Issues row_len*num_passes reads, waits N-1 cycles for the skew chain, then pulses done.
module mem_read_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12,
  parameter int N      = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [LEN_W-1:0]  row_len_i,
  input  logic [LEN_W-1:0]  num_passes_i,
  input  logic              stall_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DW = (N > 2) ? $clog2(N) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = (N > 1) ? DW'(N - 2) : '0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q, stride_q, rd_addr_q;
  logic [LEN_W-1:0]  len_q, passes_q, col_q, pass_q;
  logic              last_q, rd_en_q, busy_q, done_q;
  logic [DW-1:0]     drain_q;

  logic [ADDR_W-1:0] cur_base, cur_stride, issue_addr, base_d;
  logic [LEN_W-1:0]  cur_col, cur_pass, cur_len, cur_np, col_d, pass_d;
  logic              col_end, last_d, zero_len;

  // In IDLE the first read is formed straight from the inputs so it can issue on the start edge.
  always_comb begin
    cur_base   = base_q;
    cur_stride = stride_q;
    cur_col    = col_q;
    cur_pass   = pass_q;
    cur_len    = len_q;
    cur_np     = passes_q;
    if (state_q == IDLE) begin
      cur_base   = base_addr_i;
      cur_stride = stride_i;
      cur_col    = '0;
      cur_pass   = '0;
      cur_len    = row_len_i;
      cur_np     = num_passes_i;
    end
    issue_addr = cur_base + ADDR_W'(cur_col);
    col_end    = (cur_col == cur_len - LEN_W'(1));
    last_d     = col_end && (cur_pass == cur_np - LEN_W'(1));
    col_d      = col_end ? '0 : cur_col + LEN_W'(1);
    pass_d     = col_end ? cur_pass + LEN_W'(1) : cur_pass;
    base_d     = col_end ? cur_base + cur_stride : cur_base;
    zero_len   = (row_len_i == '0) || (num_passes_i == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      passes_q  <= '0;
      col_q     <= '0;
      pass_q    <= '0;
      last_q    <= 1'b0;
      drain_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start_i) begin
            busy_q   <= 1'b1;
            stride_q <= stride_i;
            len_q    <= row_len_i;
            passes_q <= num_passes_i;
            if (zero_len) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              rd_en_q   <= 1'b1;
              rd_addr_q <= issue_addr;
              base_q    <= base_d;
              col_q     <= col_d;
              pass_q    <= pass_d;
              last_q    <= last_d;
            end
          end
        end
        RUN: begin
          // last_q marks that the final read went out in the cycle now ending.
          if (last_q) begin
            rd_en_q <= 1'b0;
            last_q  <= 1'b0;
            if (N == 1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              drain_q <= DRAIN_INIT;
            end
          end else if (stall_i) begin
            rd_en_q <= 1'b0;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= issue_addr;
            base_q    <= base_d;
            col_q     <= col_d;
            pass_q    <= pass_d;
            last_q    <= last_d;
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mem_read_addr_gen.sv
// tb/tb_mem_read_addr_gen.sv - scoreboard bench for mem_read_addr_gen (N=4 and N=1 builds).
`timescale 1ns/1ps
module tb_mem_read_addr_gen;

  localparam int AW = 12;
  localparam int LW = 12;

  typedef struct {
    int cyc;
    int addr;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_s[2], stall_s[2], rd_en_s[2], busy_s[2], done_s[2];
  logic [AW-1:0] base_s[2], stride_s[2], rd_addr_s[2];
  logic [LW-1:0] len_s[2], passes_s[2];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  rd_t rdq[2][$];
  int  doneq[2][$];
  int  busy_lo[2], busy_hi[2];
  bit  ign[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_read_addr_gen #(.ADDR_W(AW), .LEN_W(LW), .N(4)) u_n4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[0]), .base_addr_i(base_s[0]),
    .stride_i(stride_s[0]), .row_len_i(len_s[0]), .num_passes_i(passes_s[0]),
    .stall_i(stall_s[0]), .rd_en_o(rd_en_s[0]), .rd_addr_o(rd_addr_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0])
  );

  mem_read_addr_gen #(.ADDR_W(AW), .LEN_W(LW), .N(1)) u_n1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[1]), .base_addr_i(base_s[1]),
    .stride_i(stride_s[1]), .row_len_i(len_s[1]), .num_passes_i(passes_s[1]),
    .stall_i(stall_s[1]), .rd_en_o(rd_en_s[1]), .rd_addr_o(rd_addr_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1])
  );

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (!ign[d]) begin
          if (rd_en_s[d]) begin
            chk($sformatf("rd_expected_dut%0d", d), int'(rdq[d].size() != 0), 1);
            if (rdq[d].size() != 0) begin
              rd_t e;
              e = rdq[d].pop_front();
              chk($sformatf("rd_cycle_dut%0d", d), cyc, e.cyc);
              chk($sformatf("rd_addr_dut%0d", d), int'(rd_addr_s[d]), e.addr);
            end
          end
          if (done_s[d]) begin
            chk($sformatf("done_expected_dut%0d", d), int'(doneq[d].size() != 0), 1);
            if (doneq[d].size() != 0)
              chk($sformatf("done_cycle_dut%0d", d), cyc, doneq[d].pop_front());
          end
          chk($sformatf("busy_dut%0d", d), int'(busy_s[d]),
              int'(cyc >= busy_lo[d] && cyc <= busy_hi[d]));
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic job(input int d, input int b, input int str, input int len, input int np,
                     input int addrs[$], input int stall_at, input int stall_n,
                     input int restart_at, input int tail);
    int s, last, dn;
    s = cyc;
    last = s;
    base_s[d]   = AW'(b);
    stride_s[d] = AW'(str);
    len_s[d]    = LW'(len);
    passes_s[d] = LW'(np);
    start_s[d]  = 1'b1;
    for (int k = 0; k < addrs.size(); k++) begin
      rd_t e;
      e.cyc  = s + 1 + k + ((stall_n > 0 && k >= stall_at) ? stall_n : 0);
      e.addr = addrs[k];
      rdq[d].push_back(e);
      last = e.cyc;
    end
    dn = (addrs.size() == 0) ? s + 1 : last + ((d == 0) ? 4 : 1);
    doneq[d].push_back(dn);
    busy_lo[d] = s + 1;
    busy_hi[d] = dn;
    for (int i = 1; i <= dn - s; i++) begin
      @(negedge clk);
      start_s[d]  = (i == restart_at);
      stall_s[d]  = (stall_n > 0 && i >= stall_at && i < stall_at + stall_n);
      base_s[d]   = AW'(777 * i);
      stride_s[d] = AW'(3 * i);
      len_s[d]    = LW'(2);
      passes_s[d] = LW'(2);
    end
    start_s[d] = 1'b0;
    stall_s[d] = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  initial begin
    int a[$];
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; stall_s[d] = 1'b0; base_s[d] = '0; stride_s[d] = '0;
      len_s[d] = '0; passes_s[d] = '0; busy_lo[d] = 1; busy_hi[d] = 0; ign[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rd_en", int'(rd_en_s[d]), 0);
      chk("reset_rd_addr", int'(rd_addr_s[d]), 0);
      chk("reset_busy", int'(busy_s[d]), 0);
      chk("reset_done", int'(done_s[d]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    a = {10, 11, 12, 13, 26, 27, 28, 29, 42, 43, 44, 45};
    job(0, 10, 16, 4, 3, a, 0, 0, 0, 3);
    job(0, 10, 16, 4, 3, a, 2, 2, 0, 3);
    a = {4094, 4095, 0, 1};
    job(0, 4094, 0, 4, 1, a, 0, 0, 0, 3);
    a = {};
    job(0, 5, 1, 0, 3, a, 0, 0, 0, 3);
    job(0, 5, 1, 5, 0, a, 0, 0, 0, 3);
    a = {100, 101, 150, 151};
    job(0, 100, 50, 2, 2, a, 0, 0, 2, 3);
    a = {200, 201, 202};
    job(1, 200, 0, 3, 1, a, 0, 0, 0, 1);
    a = {4090, 4091, 2, 3};
    job(1, 4090, 8, 2, 2, a, 0, 0, 0, 3);

    // Abort a running job with an asynchronous reset.
    ign[0] = 1'b1;
    ign[1] = 1'b1;
    base_s[0] = AW'(300); stride_s[0] = AW'(16); len_s[0] = LW'(4); passes_s[0] = LW'(3);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_en_before_reset", int'(rd_en_s[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_rd_en", int'(rd_en_s[0]), 0);
    chk("async_reset_busy", int'(busy_s[0]), 0);
    chk("async_reset_done", int'(done_s[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_hi[0] = -1;
    busy_hi[1] = -1;
    ign[0] = 1'b0;
    ign[1] = 1'b0;
    repeat (20) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reads_outstanding_dut%0d", d), rdq[d].size(), 0);
      chk($sformatf("dones_outstanding_dut%0d", d), doneq[d].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
